// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the frame-level AXI4-Stream arbiter/mux.
package axis_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_ACTIVE} arb_state_t;

  // Width of a port index; a single-bit index is kept even for one port.
  function automatic int grant_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester above last_grant, wrapping.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int S_COUNT = 4,
  parameter int GW      = grant_width(S_COUNT)
) (
  input  logic [S_COUNT-1:0] request,
  input  logic [GW-1:0]      last_grant,
  output logic [S_COUNT-1:0] grant,
  output logic [GW-1:0]      grant_idx
);

  logic [GW:0] cand;
  logic        found;

  // One spare bit lets last_grant+k exceed S_COUNT before the wrap subtraction.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 1; k <= S_COUNT; k++) begin
      cand = {1'b0, last_grant} + (GW+1)'(k);
      if (cand >= (GW+1)'(S_COUNT)) cand = cand - (GW+1)'(S_COUNT);
      if (!found && request[cand[GW-1:0]]) begin
        found                 = 1'b1;
        grant[cand[GW-1:0]]   = 1'b1;
        grant_idx             = cand[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/axis_frame_arb_mux.sv
// Frame-level round-robin AXI4-Stream arbiter/mux; a grant is held through tlast.
// Define AXIS_ARB_MUX_TID_TAG_EN to replace m_axis_tid with the granted port index.
module axis_frame_arb_mux
  import axis_arb_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic [S_COUNT-1:0]               s_axis_tvalid,
  output logic [S_COUNT-1:0]               s_axis_tready,
  input  logic [S_COUNT-1:0]               s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]      s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0]    s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0]    s_axis_tuser,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic [DEST_WIDTH-1:0]            m_axis_tdest,
  output logic [USER_WIDTH-1:0]            m_axis_tuser
);

  localparam int GW = grant_width(S_COUNT);

`ifdef AXIS_ARB_MUX_TID_TAG_EN
  if (ID_WIDTH < $clog2(S_COUNT)) begin : g_tid_width_check
    $error("ID_WIDTH is too narrow to carry the grant index");
  end
`endif

  arb_state_t         state;
  logic [GW-1:0]      grant_idx;
  logic [GW-1:0]      last_grant;
  logic [GW-1:0]      arb_idx;
  logic [S_COUNT-1:0] arb_grant;
  logic               out_ready;
  logic               accept;

  logic [DATA_WIDTH-1:0] in_tdata [S_COUNT];
  logic [KEEP_WIDTH-1:0] in_tkeep [S_COUNT];
  logic [ID_WIDTH-1:0]   in_tid   [S_COUNT];
  logic [DEST_WIDTH-1:0] in_tdest [S_COUNT];
  logic [USER_WIDTH-1:0] in_tuser [S_COUNT];

  for (genvar i = 0; i < S_COUNT; i++) begin : g_slice
    assign in_tdata[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign in_tkeep[i] = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
    assign in_tid[i]   = s_axis_tid[i*ID_WIDTH +: ID_WIDTH];
    assign in_tdest[i] = s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH];
    assign in_tuser[i] = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
  end

  axis_rr_arbiter #(.S_COUNT(S_COUNT)) u_arb (
    .request    (s_axis_tvalid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  // Handshake: a beat moves when tvalid && tready at a rising edge; the output
  // register takes a new beat only when it is empty or being drained this cycle.
  assign out_ready = m_axis_tready || !m_axis_tvalid;
  assign accept    = (state == ARB_ACTIVE) && s_axis_tvalid[grant_idx] && out_ready;

  always_comb begin
    s_axis_tready = '0;
    if (state == ARB_ACTIVE) s_axis_tready[grant_idx] = out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ARB_IDLE;
      grant_idx     <= '0;
      last_grant    <= GW'(S_COUNT-1);
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      m_axis_tdest  <= '0;
      m_axis_tuser  <= '0;
    end else begin
      if (m_axis_tready) m_axis_tvalid <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (|arb_grant) begin
            grant_idx  <= arb_idx;
            last_grant <= arb_idx;
            state      <= ARB_ACTIVE;
          end
        end
        ARB_ACTIVE: begin
          if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= in_tdata[grant_idx];
            m_axis_tkeep  <= in_tkeep[grant_idx];
            m_axis_tlast  <= s_axis_tlast[grant_idx];
`ifdef AXIS_ARB_MUX_TID_TAG_EN
            m_axis_tid    <= ID_WIDTH'(grant_idx);
`else
            m_axis_tid    <= in_tid[grant_idx];
`endif
            m_axis_tdest  <= in_tdest[grant_idx];
            m_axis_tuser  <= in_tuser[grant_idx];
            if (s_axis_tlast[grant_idx]) state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_arb_mux.sv
// Bench for axis_frame_arb_mux: queue-based sources, a beat-level reference model
// checked every cycle, and directed frame scenarios with literal expectations.
`timescale 1ns/1ps
module tb_axis_frame_arb_mux;

  localparam int S  = 4;
  localparam int DW = 8;
  localparam int KW = 1;
  localparam int IW = 8;
  localparam int TW = 8;
  localparam int UW = 1;
  localparam int W  = 27;   // {last, keep, id[7:0], dest[7:0], user, data[7:0]}
`ifdef AXIS_ARB_MUX_TID_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  initial forever #5 clk = ~clk;

  logic [S*DW-1:0] s_axis_tdata  = '0;
  logic [S*KW-1:0] s_axis_tkeep  = '0;
  logic [S-1:0]    s_axis_tvalid = '0;
  logic [S-1:0]    s_axis_tready;
  logic [S-1:0]    s_axis_tlast  = '0;
  logic [S*IW-1:0] s_axis_tid    = '0;
  logic [S*TW-1:0] s_axis_tdest  = '0;
  logic [S*UW-1:0] s_axis_tuser  = '0;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b1;
  logic            m_axis_tlast;
  logic [IW-1:0]   m_axis_tid;
  logic [TW-1:0]   m_axis_tdest;
  logic [UW-1:0]   m_axis_tuser;

  axis_frame_arb_mux #(
    .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
    .ID_WIDTH(IW), .DEST_WIDTH(TW), .USER_WIDTH(UW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
    .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic tog_en = 1'b0;
  logic [S-1:0] hs_s = '0;
  logic [W-1:0] src_q [S][$];
  logic [W-1:0] exp_q [$];
  logic [7:0]   log_data [$];
  logic [7:0]   log_tid  [$];
  int           log_cyc  [$];
  logic [7:0]   exp_log  [$];
  int           cur  = -1;
  int           prev = S-1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [7:0] d, input logic last, input logic [7:0] id);
    return {last, d[1], id, d ^ 8'h5A, d[0], d};
  endfunction

  task automatic push_frame(input int port, input logic [7:0] base, input int len, input logic [7:0] id);
    for (int k = 0; k < len; k++) src_q[port].push_back(mk(base + 8'(k), k == len-1, id));
  endtask

  // ---------------- driver tasks ----------------
  initial begin : driver
    logic [W-1:0] b;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < S; i++)
        if (hs_s[i] && src_q[i].size() != 0) src_q[i].delete(0);
      for (int i = 0; i < S; i++) begin
        b = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        s_axis_tvalid[i]         = (src_q[i].size() != 0);
        s_axis_tdata[i*DW +: DW] = b[7:0];
        s_axis_tuser[i]          = b[8];
        s_axis_tdest[i*TW +: TW] = b[16:9];
        s_axis_tid[i*IW +: IW]   = b[24:17];
        s_axis_tkeep[i]          = b[25];
        s_axis_tlast[i]          = b[26];
      end
      m_axis_tready = tog_en ? cyc[0] : 1'b1;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  // The output register is modelled as a queue of at most one beat; frames are
  // handed out by a modular round-robin search with one idle cycle per frame.
  initial begin : monitor
    logic [S-1:0] exp_rdy;
    logic [W-1:0] e;
    bit found;
    int p;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_outputs",
            {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tid, m_axis_tdest,
             m_axis_tuser, m_axis_tdata, s_axis_tready}, 32'h0);
        exp_q.delete();
        cur  = -1;
        prev = S-1;
        hs_s = '0;
      end else begin
        exp_rdy = '0;
        if (cur >= 0 && (exp_q.size() == 0 || m_axis_tready)) exp_rdy[cur] = 1'b1;
        chk("s_tready", 32'(s_axis_tready), 32'(exp_rdy));
        chk("m_tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0)
          chk("m_payload", 32'({m_axis_tlast, m_axis_tkeep, m_axis_tid, m_axis_tdest,
                                m_axis_tuser, m_axis_tdata}), 32'(exp_q[0]));
        hs_s = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
          log_data.push_back(m_axis_tdata);
          log_tid.push_back(m_axis_tid);
          log_cyc.push_back(cyc);
        end
        if (exp_q.size() != 0 && m_axis_tready) exp_q.delete(0);
        if (cur >= 0) begin
          if (exp_rdy[cur] && s_axis_tvalid[cur]) begin
            e = src_q[cur][0];
            if (TAG) e[24:17] = 8'(cur);
            exp_q.push_back(e);
            if (e[26]) begin
              prev = cur;
              cur  = -1;
            end
          end
        end else begin
          found = 1'b0;
          for (int d = 1; d <= S; d++) begin
            p = (prev + d) % S;
            if (!found && s_axis_tvalid[p]) begin
              found = 1'b1;
              cur   = p;
              prev  = p;
            end
          end
        end
      end
    end
  end

  // ---------------- scenario helpers ----------------
  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    for (int i = 0; i < S; i++) src_q[i].delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    log_data.delete(); log_tid.delete(); log_cyc.delete();
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    while (log_data.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (log_data.size() < n) begin
      errors++;
      $display("FAIL %s: timeout with %0d beats, expected %0d", name, log_data.size(), n);
    end
  endtask

  task automatic chk_log(input string name);
    repeat (6) @(negedge clk);
    chk({name, "_count"}, 32'(log_data.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < log_data.size(); i++)
      chk({name, "_data"}, 32'(log_data[i]), 32'(exp_log[i]));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stimulus
    int p0;
    int offs [6];
    logic [7:0] t2, t3;
    #1 rst = 1'b1;
    @(posedge clk); #2;
    chk("reset_tvalid_literal", 32'(m_axis_tvalid), 32'h0);
    chk("reset_tready_literal", 32'(s_axis_tready), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Ports 0 and 2 request together: port 0 first, one bubble, then port 2.
    do_reset();
    @(posedge clk); #2;
    p0 = cyc;
    push_frame(0, 8'h01, 3, 8'h10);
    push_frame(2, 8'h21, 3, 8'h12);
    wait_log(6, 40, "t1_wait");
    exp_log = '{8'h01, 8'h02, 8'h03, 8'h21, 8'h22, 8'h23};
    chk_log("t1");
    offs = '{3, 4, 5, 7, 8, 9};
    for (int i = 0; i < 6 && i < log_cyc.size(); i++)
      chk("t1_timing", 32'(log_cyc[i] - p0), 32'(offs[i]));

    // All ports stream single-beat frames: strict rotation, one beat every 2 cycles.
    do_reset();
    @(posedge clk); #2;
    for (int i = 0; i < S; i++) begin
      push_frame(i, 8'(i), 1, 8'h00);
      push_frame(i, 8'(i), 1, 8'h00);
    end
    wait_log(8, 60, "t2_wait");
    exp_log = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03};
    chk_log("t2");
    for (int i = 1; i < log_cyc.size(); i++)
      chk("t2_spacing", 32'(log_cyc[i] - log_cyc[i-1]), 32'd2);

    // Port 1 five-beat frame under toggling backpressure.
    do_reset();
    @(posedge clk); #2;
    tog_en = 1'b1;
    push_frame(1, 8'h10, 5, 8'h11);
    wait_log(5, 60, "t3_wait");
    exp_log = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    chk_log("t3");
    tog_en = 1'b0;

    // Port 3 owns a frame; port 0 asks mid-frame and must wait for tlast.
    do_reset();
    @(posedge clk); #2;
    push_frame(3, 8'h31, 4, 8'h13);
    wait_log(1, 20, "t4_grant");
    push_frame(0, 8'h05, 2, 8'h10);
    wait_log(6, 40, "t4_wait");
    exp_log = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h05, 8'h06};
    chk_log("t4");
    if (log_cyc.size() >= 5) chk("t4_bubble", 32'(log_cyc[4] - log_cyc[3]), 32'd2);

    // Reset lands after beat 2 of a port-1 frame while port 0 is pending.
    do_reset();
    @(posedge clk); #2;
    push_frame(1, 8'h41, 4, 8'h11);
    wait_log(1, 20, "t5_grant");
    push_frame(0, 8'h51, 2, 8'h10);
    wait_log(2, 20, "t5_beat2");
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t5_reset_tvalid", 32'(m_axis_tvalid), 32'h0);
    chk("t5_reset_tdata", 32'(m_axis_tdata), 32'h0);
    src_q[1].delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    wait_log(4, 40, "t5_wait");
    exp_log = '{8'h41, 8'h42, 8'h51, 8'h52};
    chk_log("t5");

    // tid handling on frames from ports 2 and 3 carrying tid 0xAA.
    do_reset();
    @(posedge clk); #2;
    push_frame(2, 8'h61, 2, 8'hAA);
    push_frame(3, 8'h71, 1, 8'hAA);
    wait_log(3, 40, "t6_wait");
    exp_log = '{8'h61, 8'h62, 8'h71};
    chk_log("t6");
    t2 = TAG ? 8'h02 : 8'hAA;
    t3 = TAG ? 8'h03 : 8'hAA;
    if (log_tid.size() >= 3) begin
      chk("t6_tid0", 32'(log_tid[0]), 32'(t2));
      chk("t6_tid1", 32'(log_tid[1]), 32'(t2));
      chk("t6_tid2", 32'(log_tid[2]), 32'(t3));
    end else begin
      chk("t6_tid_count", 32'(log_tid.size()), 32'd3);
    end

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
